// File: rtl/display_pkg.sv
// Shared types and helpers for the display pipeline blocks.
package display_pkg;

    typedef struct packed {
        logic cursor;
        logic underline;
        logic reverse;
    } GlyphAttr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        WRITE   = 2'd2,
        ADVANCE = 2'd3
    } GlyphRasterState_t;

    // Framebuffer words between vertically adjacent pixels of a glyph.
    function automatic int row_stride(input int columns, input int glyph_w);
        return columns * glyph_w;
    endfunction

endpackage

// File: rtl/glyph_pixel_colour.sv
// Colour of one glyph pixel: bitmap bit, underline override, reverse/cursor swap, fg/bg select.
module glyph_pixel_colour
    import display_pkg::*;
#(
    parameter int GLYPH_W       = 8,
    parameter int GLYPH_H       = 16,
    parameter int PIXEL_W       = 32,
    parameter int UNDERLINE_ROW = GLYPH_H - 2,
    parameter int XW            = 3,
    parameter int YW            = 4
) (
    input  logic [GLYPH_W*GLYPH_H-1:0] shape,
    input  logic [PIXEL_W-1:0]         fg,
    input  logic [PIXEL_W-1:0]         bg,
    input  logic [2:0]                 attr,
    input  logic [XW-1:0]              x,
    input  logic [YW-1:0]              y,
    output logic [PIXEL_W-1:0]         colour
);

    localparam int IW = $clog2(GLYPH_W * GLYPH_H);

    GlyphAttr_t    attr_s;
    logic [IW-1:0] bit_idx;
    logic          pixel_on;
    logic          swap;

    // Bitmap is row-major with pixel (0,0) in the MSB.
    always_comb begin
        attr_s   = GlyphAttr_t'(attr);
        bit_idx  = IW'(GLYPH_W * GLYPH_H - 1) - (IW'(y) * IW'(GLYPH_W) + IW'(x));
        pixel_on = shape[bit_idx] | (attr_s.underline && (y == YW'(UNDERLINE_ROW)));
        swap     = attr_s.reverse ^ attr_s.cursor;
        colour   = (pixel_on ^ swap) ? fg : bg;
    end

endmodule

// File: rtl/glyph_raster_writer.sv
// Accepts one character cell and writes all of its pixels to the SRAM framebuffer,
// one handshaked SRAM access per pixel, walking the address incrementally.
module glyph_raster_writer
    import display_pkg::*;
#(
    parameter int GLYPH_W       = 8,
    parameter int GLYPH_H       = 16,
    parameter int COLUMNS       = 80,
    parameter int ADDR_W        = 20,
    parameter int PIXEL_W       = 32,
    parameter int UNDERLINE_ROW = GLYPH_H - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [GLYPH_W*GLYPH_H-1:0] req_shape,
    input  logic [PIXEL_W-1:0]         req_fg,
    input  logic [PIXEL_W-1:0]         req_bg,
    input  logic [2:0]                 req_attr,
    input  logic [ADDR_W-1:0]          req_base,
    output logic [ADDR_W-1:0]          sram_addr,
    output logic [PIXEL_W-1:0]         sram_dout,
    output logic                       sram_den,
    output logic                       sram_we_n,
    output logic                       sram_oe_n,
    input  logic                       sram_done,
    output logic                       busy,
    output logic                       done
);

    localparam int XW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int YW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(row_stride(COLUMNS, GLYPH_W));

    localparam logic [1:0] S_IDLE    = 2'(IDLE);
    localparam logic [1:0] S_SETUP   = 2'(SETUP);
    localparam logic [1:0] S_WRITE   = 2'(WRITE);
    localparam logic [1:0] S_ADVANCE = 2'(ADVANCE);

    logic [1:0]                 state_reg;
    logic [GLYPH_W*GLYPH_H-1:0] shape_reg;
    logic [PIXEL_W-1:0]         fg_reg;
    logic [PIXEL_W-1:0]         bg_reg;
    logic [2:0]                 attr_reg;
    logic [ADDR_W-1:0]          base_reg;
    logic [XW-1:0]              x_reg;
    logic [YW-1:0]              y_reg;
    logic [ADDR_W-1:0]          row_addr_reg;
    logic [ADDR_W-1:0]          sram_addr_reg;
    logic [PIXEL_W-1:0]         sram_dout_reg;
    logic                       done_reg;

    logic [XW-1:0]      x_next;
    logic [YW-1:0]      y_next;
    logic               x_wrap;
    logic               last_pixel;
    logic [PIXEL_W-1:0] colour_next;

    // Coordinates of the pixel to be presented in the coming WRITE.
    always_comb begin
        x_next     = '0;
        y_next     = y_reg;
        x_wrap     = 1'b0;
        last_pixel = (x_reg == XW'(GLYPH_W - 1)) && (y_reg == YW'(GLYPH_H - 1));
        if (state_reg == S_SETUP) begin
            y_next = '0;
        end else if (x_reg == XW'(GLYPH_W - 1)) begin
            x_wrap = 1'b1;
            y_next = y_reg + YW'(1);
        end else begin
            x_next = x_reg + XW'(1);
        end
    end

    glyph_pixel_colour #(
        .GLYPH_W      (GLYPH_W),
        .GLYPH_H      (GLYPH_H),
        .PIXEL_W      (PIXEL_W),
        .UNDERLINE_ROW(UNDERLINE_ROW),
        .XW           (XW),
        .YW           (YW)
    ) u_pixel (
        .shape (shape_reg),
        .fg    (fg_reg),
        .bg    (bg_reg),
        .attr  (attr_reg),
        .x     (x_next),
        .y     (y_next),
        .colour(colour_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            x_reg         <= '0;
            y_reg         <= '0;
            row_addr_reg  <= '0;
            sram_addr_reg <= '0;
            sram_dout_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        shape_reg <= req_shape;
                        fg_reg    <= req_fg;
                        bg_reg    <= req_bg;
                        attr_reg  <= req_attr;
                        base_reg  <= req_base;
                        state_reg <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    x_reg         <= '0;
                    y_reg         <= '0;
                    row_addr_reg  <= base_reg;
                    sram_addr_reg <= base_reg;
                    sram_dout_reg <= colour_next;
                    state_reg     <= S_WRITE;
                end
                S_WRITE: begin
                    if (sram_done) begin
                        if (last_pixel) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_IDLE;
                        end else begin
                            state_reg <= S_ADVANCE;
                        end
                    end
                end
                S_ADVANCE: begin
                    // Address steps by one within a row and by the stride on a row change;
                    // both wrap at 2^ADDR_W.
                    x_reg <= x_next;
                    y_reg <= y_next;
                    if (x_wrap) begin
                        row_addr_reg  <= row_addr_reg + ROW_STRIDE;
                        sram_addr_reg <= row_addr_reg + ROW_STRIDE;
                    end else begin
                        sram_addr_reg <= sram_addr_reg + ADDR_W'(1);
                    end
                    sram_dout_reg <= colour_next;
                    state_reg     <= S_WRITE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign done      = done_reg;
    assign sram_addr = sram_addr_reg;
    assign sram_dout = sram_dout_reg;
    assign sram_den  = (state_reg == S_WRITE);
    assign sram_we_n = (state_reg != S_WRITE);
    assign sram_oe_n = 1'b1;

endmodule

// File: tb/tb_glyph_raster_writer.sv
// Randomised bench for glyph_raster_writer: a monitor logs completed SRAM writes and done
// pulses; each test compares the log against a pixel-by-pixel reference of the cell.
module tb_glyph_raster_writer;

    localparam int GW   = 8;
    localparam int GH   = 16;
    localparam int COLS = 80;
    localparam int NPIX = GW * GH;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_shape;
    logic [31:0]  req_fg;
    logic [31:0]  req_bg;
    logic [2:0]   req_attr;
    logic [19:0]  req_base;
    logic [19:0]  sram_addr;
    logic [31:0]  sram_dout;
    logic         sram_den;
    logic         sram_we_n;
    logic         sram_oe_n;
    logic         sram_done;
    logic         busy;
    logic         done;

    glyph_raster_writer #(
        .GLYPH_W(GW), .GLYPH_H(GH), .COLUMNS(COLS), .ADDR_W(20), .PIXEL_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_shape(req_shape),
        .req_fg(req_fg), .req_bg(req_bg), .req_attr(req_attr), .req_base(req_base),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_den(sram_den),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_done(sram_done),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int accept_cyc;
    int max_delay = 0;
    int unstable = 0;
    int wait_left = 0;
    bit phase_open = 0;
    bit drv_phase = 0;
    logic [19:0] held_addr;
    logic [31:0] held_data;

    logic [19:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [19:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          done_times[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // SRAM controller model: random completion delay inside WRITE, random noise outside it.
    always @(posedge clk) begin
        #1;
        if (sram_den) begin
            if (!drv_phase) begin
                drv_phase = 1;
                wait_left = $urandom_range(0, max_delay);
            end
            if (wait_left > 0) begin
                sram_done = 1'b0;
                wait_left--;
            end else begin
                sram_done = 1'b1;
                drv_phase = 0;
            end
        end else begin
            drv_phase = 0;
            sram_done = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: records completed writes, done pulses and any bus movement mid-access.
    always @(negedge clk) begin
        if (sram_den !== ~sram_we_n) unstable++;
        if (sram_den === 1'b1) begin
            if (phase_open && (sram_addr !== held_addr || sram_dout !== held_data)) unstable++;
            phase_open = 1;
            held_addr  = sram_addr;
            held_data  = sram_dout;
            if (sram_done === 1'b1) begin
                obs_addr.push_back(sram_addr);
                obs_data.push_back(sram_dout);
                phase_open = 0;
            end
        end else begin
            phase_open = 0;
        end
        if (done === 1'b1) done_times.push_back(cyc_cnt);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        obs_addr.delete(); obs_data.delete();
        exp_addr.delete(); exp_data.delete();
        done_times.delete();
        unstable = 0;
    endtask

    // Reference: geometry and colour rules evaluated directly per pixel.
    task automatic model_cell(input logic [127:0] shape, input logic [31:0] fg,
                              input logic [31:0] bg, input logic [2:0] attr,
                              input logic [19:0] base);
        for (int y = 0; y < GH; y++) begin
            logic [7:0] row_bits;
            row_bits = shape[(GH - 1 - y) * GW +: GW];
            for (int x = 0; x < GW; x++) begin
                bit on;
                bit swp;
                int a;
                on  = row_bits[GW - 1 - x] || (attr[1] && y == GH - 2);
                swp = attr[0] ^ attr[2];
                a   = (int'(base) + y * COLS * GW + x) % (1 << 20);
                exp_addr.push_back(20'(a));
                exp_data.push_back((on ^ swp) ? fg : bg);
            end
        end
    endtask

    task automatic send_cell(input logic [127:0] shape, input logic [31:0] fg,
                             input logic [31:0] bg, input logic [2:0] attr,
                             input logic [19:0] base, input bit drop_valid);
        int guard;
        req_shape = shape; req_fg = fg; req_bg = bg; req_attr = attr; req_base = base;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 2000) begin
            step();
            guard++;
        end
        accept_cyc = cyc_cnt;
        step();
        if (drop_valid) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 5000) begin
            step();
            guard++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required busy=0", busy, guard);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks += 8;
        if (sram_addr !== 20'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
        if (sram_dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h want 0", sram_dout); end
        if (sram_den !== 1'b0)   begin errors++; $display("FAIL reset_den: got %b want 0", sram_den); end
        if (sram_we_n !== 1'b1)  begin errors++; $display("FAIL reset_we_n: got %b want 1", sram_we_n); end
        if (sram_oe_n !== 1'b1)  begin errors++; $display("FAIL reset_oe_n: got %b want 1", sram_oe_n); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (req_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        rst = 1'b0;
        step();
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        int nbad = 0;
        clear_logs();
        max_delay = 0;
        model_cell({16{8'hAA}}, 32'h00FF_FFFF, 32'h0, 3'b000, 20'h0);
        send_cell({16{8'hAA}}, 32'h00FF_FFFF, 32'h0, 3'b000, 20'h0, 1'b1);
        wait_idle();
        checks++;
        if (obs_addr.size() != NPIX) begin errors++; $display("FAIL basic_count: got %0d want %0d", obs_addr.size(), NPIX); end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                errors++; nbad++;
                if (nbad < 5) $display("FAIL basic_pixel[%0d]: got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks += 2;
        if (done_times.size() != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_times.size()); end
        else if (done_times[0] - accept_cyc != 2 * NPIX + 1) begin
            errors++; $display("FAIL basic_latency: got %0d want %0d", done_times[0] - accept_cyc, 2 * NPIX + 1);
        end
        if (unstable != 0) begin errors++; $display("FAIL basic_stable: got %0d glitches want 0", unstable); end
        $display("test_basic: writes=%0d done=%0d", obs_addr.size(), done_times.size());
    endtask

    task automatic test_attr();
        logic [2:0] attrs[3];
        attrs[0] = 3'b001; attrs[1] = 3'b101; attrs[2] = 3'b010;
        for (int t = 0; t < 3; t++) begin
            logic [31:0] fg;
            logic [31:0] bg;
            int nbad = 0;
            fg = $urandom; bg = $urandom;
            if (fg == bg) bg = ~fg;
            clear_logs();
            model_cell(128'h0, fg, bg, attrs[t], 20'h0);
            send_cell(128'h0, fg, bg, attrs[t], 20'h0, 1'b1);
            wait_idle();
            checks++;
            if (obs_addr.size() != NPIX) begin errors++; $display("FAIL attr%0d_count: got %0d want %0d", t, obs_addr.size(), NPIX); end
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
                checks++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    errors++; nbad++;
                    if (nbad < 5) $display("FAIL attr%0d_pixel[%0d]: got %h/%h want %h/%h", t, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
                end
            end
            $display("test_attr: attr=%b writes=%0d", attrs[t], obs_addr.size());
        end
    endtask

    task automatic test_delay();
        for (int t = 0; t < 3; t++) begin
            logic [127:0] shape;
            logic [31:0]  fg;
            logic [31:0]  bg;
            logic [2:0]   attr;
            logic [19:0]  base;
            int nbad = 0;
            shape = {$urandom, $urandom, $urandom, $urandom};
            fg = $urandom; bg = $urandom;
            attr = 3'($urandom_range(0, 7));
            base = 20'($urandom);
            clear_logs();
            max_delay = 5;
            model_cell(shape, fg, bg, attr, base);
            send_cell(shape, fg, bg, attr, base, 1'b1);
            wait_idle();
            checks += 3;
            if (obs_addr.size() != NPIX) begin errors++; $display("FAIL delay_count: got %0d want %0d", obs_addr.size(), NPIX); end
            if (unstable != 0) begin errors++; $display("FAIL delay_stable: got %0d glitches want 0", unstable); end
            if (done_times.size() != 1) begin errors++; $display("FAIL delay_done_count: got %0d want 1", done_times.size()); end
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
                checks++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    errors++; nbad++;
                    if (nbad < 5) $display("FAIL delay_pixel[%0d]: got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
                end
            end
            $display("test_delay: base=%h attr=%b writes=%0d", base, attr, obs_addr.size());
        end
        max_delay = 0;
    endtask

    task automatic test_wrap();
        logic [127:0] shape;
        int nbad = 0;
        shape = {$urandom, $urandom, $urandom, $urandom};
        clear_logs();
        model_cell(shape, 32'h1234_5678, 32'h9ABC_DEF0, 3'b000, 20'hFFFFC);
        send_cell(shape, 32'h1234_5678, 32'h9ABC_DEF0, 3'b000, 20'hFFFFC, 1'b1);
        wait_idle();
        checks++;
        if (obs_addr.size() != NPIX) begin errors++; $display("FAIL wrap_count: got %0d want %0d", obs_addr.size(), NPIX); end
        else begin
            checks += 2;
            if (obs_addr[3] !== 20'hFFFFF) begin errors++; $display("FAIL wrap_addr3: got %h want fffff", obs_addr[3]); end
            if (obs_addr[4] !== 20'h00000) begin errors++; $display("FAIL wrap_addr4: got %h want 00000", obs_addr[4]); end
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                errors++; nbad++;
                if (nbad < 5) $display("FAIL wrap_pixel[%0d]: got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        $display("test_wrap: first=%h writes=%0d", (obs_addr.size() > 0) ? obs_addr[0] : 20'h0, obs_addr.size());
    endtask

    task automatic test_reset_mid();
        logic [127:0] shape;
        logic [19:0]  base;
        int guard = 0;
        int nbad = 0;
        shape = {$urandom, $urandom, $urandom, $urandom};
        clear_logs();
        send_cell(shape, 32'hAAAA_0000, 32'h0000_5555, 3'b000, 20'h01000, 1'b1);
        while (!(obs_addr.size() == 36 && sram_den) && guard < 2000) begin
            step();
            guard++;
        end
        rst = 1'b1;
        step();
        checks += 4;
        if (sram_den !== 1'b0)  begin errors++; $display("FAIL rstmid_den: got %b want 0", sram_den); end
        if (sram_we_n !== 1'b1) begin errors++; $display("FAIL rstmid_we_n: got %b want 1", sram_we_n); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (done_times.size() != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_times.size()); end
        base = 20'($urandom);
        clear_logs();
        model_cell(shape, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b010, base);
        send_cell(shape, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b010, base, 1'b1);
        wait_idle();
        checks++;
        if (obs_addr.size() != NPIX) begin errors++; $display("FAIL rstmid_count: got %0d want %0d", obs_addr.size(), NPIX); end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                errors++; nbad++;
                if (nbad < 5) $display("FAIL rstmid_pixel[%0d]: got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        $display("test_reset_mid: restart base=%h writes=%0d", base, obs_addr.size());
    endtask

    task automatic test_back_to_back();
        logic [127:0] shape_a;
        logic [127:0] shape_b;
        logic [19:0]  base_a;
        logic [19:0]  base_b;
        int guard = 0;
        int nbad = 0;
        shape_a = {$urandom, $urandom, $urandom, $urandom};
        shape_b = {$urandom, $urandom, $urandom, $urandom};
        base_a = 20'($urandom);
        base_b = 20'($urandom);
        clear_logs();
        model_cell(shape_a, 32'h1111_1111, 32'h2222_2222, 3'b001, base_a);
        model_cell(shape_b, 32'h3333_3333, 32'h4444_4444, 3'b110, base_b);
        send_cell(shape_a, 32'h1111_1111, 32'h2222_2222, 3'b001, base_a, 1'b0);
        // Keep valid high with junk while busy; offer cell B in the done cycle.
        while (!done && guard < 2000) begin
            req_shape = {$urandom, $urandom, $urandom, $urandom};
            req_fg = $urandom; req_bg = $urandom;
            req_attr = 3'($urandom); req_base = 20'($urandom);
            step();
            guard++;
        end
        req_shape = shape_b; req_fg = 32'h3333_3333; req_bg = 32'h4444_4444;
        req_attr = 3'b110; req_base = base_b;
        step();
        req_valid = 1'b0;
        wait_idle();
        checks += 2;
        if (obs_addr.size() != 2 * NPIX) begin errors++; $display("FAIL b2b_count: got %0d want %0d", obs_addr.size(), 2 * NPIX); end
        if (done_times.size() != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_times.size()); end
        else begin
            checks++;
            if (done_times[1] - done_times[0] != 2 * NPIX + 1) begin
                errors++; $display("FAIL b2b_gap: got %0d want %0d", done_times[1] - done_times[0], 2 * NPIX + 1);
            end
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                errors++; nbad++;
                if (nbad < 5) $display("FAIL b2b_pixel[%0d]: got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        $display("test_back_to_back: writes=%0d done=%0d", obs_addr.size(), done_times.size());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_shape = '0; req_fg = '0; req_bg = '0; req_attr = '0; req_base = '0;
        sram_done = 1'b0;
        test_reset();
        test_basic();
        test_attr();
        test_delay();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
